store_buffer: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/store_buffer_match.sv | 32 +++
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: word geometry and the store buffer entry layout.
package mips_mem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BYTE_OFF = 2;
    localparam int unsigned WADDR_W  = WORD_W - BYTE_OFF;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [WORD_W-1:0]  data;
    } sb_entry_t;

    // Word-aligned byte address from a word index.
    function automatic logic [WORD_W-1:0] word_to_byte(input logic [WADDR_W-1:0] waddr);
        return {waddr, {BYTE_OFF{1'b0}}};
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over the buffered stores for load forwarding.
module store_buffer_match
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PW-1:0]      tail,
    input  logic [WADDR_W-1:0] ld_waddr,
    output logic               hit,
    output logic [WORD_W-1:0]  data
);

    logic [PW-1:0] idx;

    // Walk from oldest slot (tail-DEPTH) to youngest (tail-1); later matches override.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (valid[idx] && (entries[idx].waddr == ld_waddr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port data memory; loads own the port.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter bit          CHECK_ONE_OP = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_hit,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t          entries [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic [DEPTH-1:0]   valid;
    logic [PW-1:0]      age;
    logic [WADDR_W-1:0] ld_waddr;
    logic               match_hit;
    logic [WORD_W-1:0]  match_data;
    logic               push;
    logic               pop;

    assign ld_waddr = WADDR_W'(ld_addr[AW-1:BYTE_OFF]);

    // Slot i is live when its distance from head is below the occupancy.
    always_comb begin
        valid = '0;
        age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - head;
            valid[i] = (CW'(age) < count);
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_match (
        .entries  (entries),
        .valid    (valid),
        .tail     (tail),
        .ld_waddr (ld_waddr),
        .hit      (match_hit),
        .data     (match_data)
    );

    // Port arbitration: a missing load takes memory, otherwise the head entry drains.
    always_comb begin
        empty     = (count == '0);
        st_ready  = (count != CW'(DEPTH));
        push      = st_valid && st_ready;
        ld_hit    = ld_valid && match_hit;
        mem_read  = ld_valid && !match_hit;
        pop       = !empty && !mem_read;
        mem_write = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_data   = '0;
        if (ld_hit) begin
            ld_data = DW'(match_data);
        end else if (ld_valid) begin
            ld_data = mem_rdata;
        end
        if (mem_read) begin
            mem_addr = {ld_addr[AW-1:BYTE_OFF], {BYTE_OFF{1'b0}}};
        end else if (pop) begin
            mem_addr  = AW'(word_to_byte(entries[head].waddr));
            mem_wdata = DW'(entries[head].data);
        end
    end

    // Pointer and occupancy update; push and pop may coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; validity comes from the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{waddr: WADDR_W'(st_addr[AW-1:BYTE_OFF]),
                               data:  WORD_W'(st_data)};
        end
    end

    // One memory operation per instruction: a store and a load never share a cycle.
    always_ff @(posedge clk) begin
        if (CHECK_ONE_OP && !reset) begin
            assert (!(st_valid && ld_valid))
                else $error("store_buffer: store and load presented in the same cycle");
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small word-addressed memory model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        empty;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Fill scenarios hold a stalled load while stores arrive, so the one-op check is off.
    store_buffer #(
        .DEPTH        (4),
        .AW           (32),
        .DW           (32),
        .CHECK_ONE_OP (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_hit    (ld_hit),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .empty     (empty)
    );

    // Memory: combinational read, write committed at the clock edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;

        // Reset values before any clock edge
        #2;
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_ld_hit", 32'(ld_hit), 32'd0);
        check("rst_ld_data", ld_data, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Single store drains next cycle, then a load reads it from memory
        store(32'h10, 32'hDEADBEEF);
        #1;
        check("s1_no_write_empty", 32'(mem_write), 32'd0);
        tick();
        st_valid = 1'b0;
        #1;
        check("s1_mem_write", 32'(mem_write), 32'd1);
        check("s1_mem_addr", mem_addr, 32'h10);
        check("s1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("s1_not_empty", 32'(empty), 32'd0);
        tick();
        check("s1_empty_after", 32'(empty), 32'd1);
        ld_valid = 1'b1;
        ld_addr  = 32'h10;
        #1;
        check("s1_ld_read", 32'(mem_read), 32'd1);
        check("s1_ld_hit", 32'(ld_hit), 32'd0);
        check("s1_ld_addr", mem_addr, 32'h10);
        check("s1_ld_data", ld_data, 32'hDEADBEEF);

        // Fill behind a missing load; the fifth store waits for space
        ld_addr = 32'h100;
        store(32'h0, 32'hA000);
        #1;
        check("f_mem_write_blocked", 32'(mem_write), 32'd0);
        tick();
        store(32'h4, 32'hA004);
        tick();
        store(32'h8, 32'hA008);
        tick();
        store(32'hC, 32'hA00C);
        #1;
        check("f_ready_at3", 32'(st_ready), 32'd1);
        tick();
        store(32'h14, 32'hA014);
        #1;
        check("f_full_ready", 32'(st_ready), 32'd0);
        check("f_full_read", 32'(mem_read), 32'd1);
        tick();
        check("f_still_full", 32'(st_ready), 32'd0);
        ld_valid = 1'b0;
        #1;
        check("f_d0_write", 32'(mem_write), 32'd1);
        check("f_d0_addr", mem_addr, 32'h0);
        check("f_d0_data", mem_wdata, 32'hA000);
        check("f_d0_ready", 32'(st_ready), 32'd0);
        tick();
        check("f_d1_addr", mem_addr, 32'h4);
        check("f_d1_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        #1;
        check("f_d2_addr", mem_addr, 32'h8);
        tick();
        check("f_d3_addr", mem_addr, 32'hC);
        tick();
        check("f_d4_addr", mem_addr, 32'h14);
        check("f_d4_data", mem_wdata, 32'hA014);
        tick();
        check("f_empty", 32'(empty), 32'd1);
        check("f_mem_0", mem[0], 32'hA000);
        check("f_mem_c", mem[3], 32'hA00C);

        // Youngest of two same-word stores is forwarded while the older drains
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        store(32'h20, 32'h1);
        tick();
        store(32'h20, 32'h2);
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h22;
        #1;
        check("y_hit", 32'(ld_hit), 32'd1);
        check("y_data", ld_data, 32'h2);
        check("y_no_read", 32'(mem_read), 32'd0);
        check("y_drain_write", 32'(mem_write), 32'd1);
        check("y_drain_addr", mem_addr, 32'h20);
        check("y_drain_data", mem_wdata, 32'h1);
        tick();
        check("y2_hit", 32'(ld_hit), 32'd1);
        check("y2_data", ld_data, 32'h2);
        check("y2_drain_data", mem_wdata, 32'h2);
        tick();
        check("y3_miss_read", 32'(mem_read), 32'd1);
        check("y3_mem_data", ld_data, 32'h2);

        // Push and pop together at DEPTH-1; new entry drains last
        ld_addr = 32'h100;
        store(32'h30, 32'hA0);
        tick();
        store(32'h34, 32'hA4);
        tick();
        store(32'h38, 32'hA8);
        tick();
        ld_valid = 1'b0;
        store(32'h3C, 32'hAC);
        #1;
        check("p_ready", 32'(st_ready), 32'd1);
        check("p_write", 32'(mem_write), 32'd1);
        check("p_addr", mem_addr, 32'h30);
        tick();
        st_valid = 1'b0;
        #1;
        check("p_ready_after", 32'(st_ready), 32'd1);
        check("p_d1_addr", mem_addr, 32'h34);
        tick();
        check("p_d2_addr", mem_addr, 32'h38);
        tick();
        check("p_d3_addr", mem_addr, 32'h3C);
        check("p_d3_data", mem_wdata, 32'hAC);
        tick();
        check("p_empty", 32'(empty), 32'd1);

        // Reset mid-drain discards entries without a clock edge
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        store(32'h40, 32'hB0);
        tick();
        store(32'h44, 32'hB4);
        tick();
        store(32'h48, 32'hB8);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("r_write_before", 32'(mem_write), 32'd1);
        check("r_addr_before", mem_addr, 32'h40);
        reset = 1'b1;
        #1;
        check("r_write_drop", 32'(mem_write), 32'd0);
        check("r_empty_now", 32'(empty), 32'd1);
        check("r_ready_now", 32'(st_ready), 32'd1);
        tick();
        reset = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h44;
        #1;
        check("r_ld_hit", 32'(ld_hit), 32'd0);
        check("r_ld_read", 32'(mem_read), 32'd1);
        check("r_ld_data", ld_data, 32'h0);
        check("r_empty", 32'(empty), 32'd1);
        ld_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
